// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: state encodings and widths shared by the run controller and scanner
package counter_ctrl_pkg;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam int DIGIT_W = 3;
  localparam int DATA_W  = 4;
endpackage

// File: rtl/digit_scan.sv
// digit_scan: free-running multiplexer driving one seven-segment decoder across all digits
module digit_scan
  import counter_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 250
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] cnt_i,
  output logic [NUM_DIGITS-1:0]         sel_o,
  output logic [DATA_W-1:0]             data_o
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  logic [SW-1:0] sc_q, sc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          adv;
  always_comb begin
    adv   = sc_q == SW'(SCAN_DIV - 1);
    sc_d  = adv ? '0 : sc_q + 1'b1;
    idx_d = !adv ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sc_q  <= '0;
      idx_q <= '0;
    end else begin
      sc_q  <= sc_d;
      idx_q <= idx_d;
    end
  assign sel_o  = ~(NUM_DIGITS'(1) << idx_q);
  assign data_o = {1'b0, cnt_i[DIGIT_W*idx_q +: DIGIT_W]};
endmodule

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: run/pause/step FSM, prescaler and octal ripple counter with display scan
module counter_run_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000,
  parameter int SCAN_DIV   = 250
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic                          iStart,
  input  logic                          iPause,
  input  logic                          iClear,
  input  logic                          iStep,
  output logic [1:0]                    oState,
  output logic [DIGIT_W*NUM_DIGITS-1:0] oCount,
  output logic                          oWrap,
  output logic [NUM_DIGITS-1:0]         oDigitSel,
  output logic [DATA_W-1:0]             oDigitData
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = DIGIT_W * NUM_DIGITS;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic          idle, run, tick, inc;
  // Binary +1 on the packed octal digits is the same as the per-digit ripple carry.
  always_comb begin
    idle    = state_q == ST_IDLE;
    run     = state_q == ST_RUN;
    tick    = run && pre_q == PW'(TICK_DIV - 1);
    inc     = !iClear && (run ? !iPause && tick : idle ? !iStart && iStep : !iPause && !iStart && iStep);
    state_d = iClear ? ST_IDLE : run ? (iPause ? ST_PAUSE : ST_RUN) : (iStart && (idle || !iPause)) ? ST_RUN : state_q;
    pre_d   = (iClear || idle) ? '0 : !run || iPause ? pre_q : tick ? '0 : pre_q + 1'b1;
    cnt_d   = iClear ? '0 : inc ? cnt_q + CW'(1) : cnt_q;
    wrap_d  = inc && &cnt_q;
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  assign oState = state_q;
  assign oCount = cnt_q;
  assign oWrap  = wrap_q;
  digit_scan #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk_i  (CLK),
    .rst_ni (rst_n),
    .cnt_i  (cnt_q),
    .sel_o  (oDigitSel),
    .data_o (oDigitData)
  );
endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl: directed checks of run/pause/step/clear, wrap and display scan
module tb_counter_run_ctrl;
  logic       CLK = 1'b0, rst_n = 1'b1;
  logic       iStart = 1'b0, iPause = 1'b0, iClear = 1'b0, iStep = 1'b0;
  logic [1:0] oState, oDigitSel;
  logic [5:0] oCount;
  logic       oWrap;
  logic [3:0] oDigitData;
  int         total = 0, bad = 0, ecnt = 0;
  counter_run_ctrl #(.NUM_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2)) dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .iStart     (iStart),
    .iPause     (iPause),
    .iClear     (iClear),
    .iStep      (iStep),
    .oState     (oState),
    .oCount     (oCount),
    .oWrap      (oWrap),
    .oDigitSel  (oDigitSel),
    .oDigitData (oDigitData)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else ecnt <= ecnt + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic scan_chk(input string tag, input logic [5:0] c);
    logic [1:0] es;
    es = ((ecnt / 2) % 2) != 0 ? 2'b01 : 2'b10;
    chk({tag, "_sel"}, oDigitSel, es);
    chk({tag, "_data"}, oDigitData, es == 2'b10 ? {1'b0, c[2:0]} : {1'b0, c[5:3]});
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", oState, 2'b00);
    chk("rst_count", oCount, 0);
    chk("rst_wrap", oWrap, 0);
    chk("rst_sel", oDigitSel, 2'b10);
    chk("rst_data", oDigitData, 0);
    @(negedge CLK) rst_n = 1'b1;
    iStart = 1'b1;
    cyc(1);
    iStart = 1'b0;
    chk("run_state", oState, 2'b01);
    chk("run_c0", oCount, 0);
    cyc(3);
    chk("run_e3", oCount, 0);
    cyc(1);
    chk("run_e4", oCount, 1);
    cyc(4);
    chk("run_e8", oCount, 2);
    cyc(247);
    chk("run_e255", oCount, 6'o77);
    chk("nowrap_e255", oWrap, 0);
    cyc(1);
    chk("wrap_cnt", oCount, 0);
    chk("wrap_hi", oWrap, 1);
    cyc(1);
    chk("wrap_lo", oWrap, 0);
    iPause = 1'b1;
    cyc(1);
    iPause = 1'b0;
    chk("pause_state", oState, 2'b10);
    chk("pause_cnt", oCount, 0);
    iStep = 1'b1;
    cyc(1);
    chk("step1", oCount, 1);
    cyc(1);
    chk("step2", oCount, 2);
    iStep = 1'b0;
    iStart = 1'b1;
    cyc(1);
    iStart = 1'b0;
    chk("resume_state", oState, 2'b01);
    chk("resume_cnt", oCount, 2);
    cyc(2);
    chk("resume_r2", oCount, 2);
    cyc(1);
    chk("resume_r3", oCount, 3);
    iClear = 1'b1;
    cyc(1);
    iClear = 1'b0;
    chk("clr_state", oState, 2'b00);
    iStep = 1'b1;
    cyc(63);
    iStep = 1'b0;
    chk("held_step", oCount, 6'o77);
    iStart = 1'b1;
    cyc(1);
    iStart = 1'b0;
    cyc(3);
    chk("pre_tick_cnt", oCount, 6'o77);
    iClear = 1'b1;
    iPause = 1'b1;
    cyc(1);
    iClear = 1'b0;
    iPause = 1'b0;
    chk("clrpause_state", oState, 2'b00);
    chk("clrpause_cnt", oCount, 0);
    chk("clrpause_wrap", oWrap, 0);
    cyc(1);
    chk("clrpause_wrap2", oWrap, 0);
    iStep = 1'b1;
    cyc(42);
    iStep = 1'b0;
    chk("scan_cnt", oCount, 6'o52);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      scan_chk("scan_idle", 6'o52);
    end
    iStart = 1'b1;
    cyc(1);
    iStart = 1'b0;
    iPause = 1'b1;
    cyc(1);
    iPause = 1'b0;
    chk("scan_pause_state", oState, 2'b10);
    for (int i = 0; i < 4; i++) begin
      scan_chk("scan_pause", 6'o52);
      cyc(1);
    end
    iClear = 1'b1;
    cyc(1);
    iClear = 1'b0;
    iStep = 1'b1;
    cyc(25);
    iStep = 1'b0;
    iStart = 1'b1;
    cyc(1);
    iStart = 1'b0;
    cyc(1);
    chk("mid_state", oState, 2'b01);
    chk("mid_cnt", oCount, 6'o31);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", oState, 2'b00);
    chk("arst_count", oCount, 0);
    chk("arst_wrap", oWrap, 0);
    chk("arst_sel", oDigitSel, 2'b10);
    chk("arst_data", oDigitData, 0);
    @(negedge CLK) rst_n = 1'b1;
    iStart = 1'b1;
    cyc(1);
    iStart = 1'b0;
    chk("post_state", oState, 2'b01);
    scan_chk("post_scan", 6'o00);
    cyc(3);
    chk("post_e3", oCount, 0);
    cyc(1);
    chk("post_e4", oCount, 1);
    scan_chk("post_scan2", 6'o01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
